// File: rtl/buttons_pkg.sv
// -----------------------------------------------------------------------------
// buttons_pkg
// Shared constants for the memory-mapped button peripheral: register offsets
// (decoded from address bits [3:2]) and the bit positions of the two interrupt
// enable fields inside the IRQEN register.
// -----------------------------------------------------------------------------
package buttons_pkg;

    // Register selector, taken directly from address_in[3:2].
    typedef enum logic [1:0] {
        REG_STATE   = 2'd0,
        REG_PRESS   = 2'd1,
        REG_RELEASE = 2'd2,
        REG_IRQEN   = 2'd3
    } reg_sel_e;

    // IRQEN layout: press enables in byte 0, release enables in byte 1.
    localparam int IRQEN_PRESS_LSB   = 0;
    localparam int IRQEN_RELEASE_LSB = 8;

    // Largest supported button count; both IRQEN fields must fit in one byte.
    localparam int MAX_BUTTONS = 8;

endpackage : buttons_pkg

// File: rtl/button_debounce_cell.sv
// -----------------------------------------------------------------------------
// button_debounce_cell
// One button: polarity correction, 2-flop synchroniser and a counter-based
// debouncer. The synchronised level has to differ from the accepted level for
// DEBOUNCE_CYCLES consecutive cycles before it is accepted.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   raw_in     raw asynchronous button pin
//   stable_out debounced (accepted) level, 1 = pressed
//   rise_out   one-cycle pulse in the cycle a 0->1 transition is accepted
//   fall_out   one-cycle pulse in the cycle a 1->0 transition is accepted
// -----------------------------------------------------------------------------
module button_debounce_cell #(
    parameter int DEBOUNCE_CYCLES = 36000,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic stable_out,
    output logic rise_out,
    output logic fall_out
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          level;
    logic          sync_p0;
    logic          sync_p1;
    logic [CW-1:0] cnt;
    logic          stable;
    logic          accept;

    // Normalise polarity so that 1 always means "pressed" downstream.
    assign level = raw_in ^ ACTIVE_LOW;

    // The candidate level has been different for the full window this cycle.
    assign accept = (sync_p1 != stable) && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            cnt     <= '0;
            stable  <= 1'b0;
        end else begin
            // stage p0 -> p1: metastability filter
            sync_p0 <= level;
            sync_p1 <= sync_p0;
            // stage p1 -> stable: any return to the accepted level restarts
            // the window, so a glitch shorter than the window never lands.
            if (sync_p1 == stable) begin
                cnt <= '0;
            end else if (accept) begin
                stable <= sync_p1;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Pulses coincide with the edge that loads stable, so the event register
    // in the parent sets on the same edge that the level changes.
    assign stable_out = stable;
    assign rise_out   = accept &  sync_p1;
    assign fall_out   = accept & ~sync_p1;

endmodule : button_debounce_cell

// File: rtl/buttons_dev.sv
// -----------------------------------------------------------------------------
// buttons_dev
// Memory-mapped button peripheral. Each button is debounced by its own
// button_debounce_cell; this module holds the sticky PRESS/RELEASE event
// registers, the interrupt enables, the bus decode and the interrupt output.
//
// Register map (address_in[3:2]):
//   0x0 STATE   RO   debounced levels
//   0x4 PRESS   W1C  sticky press events    (byte 0)
//   0x8 RELEASE W1C  sticky release events  (byte 0)
//   0xC IRQEN   RW   press enables byte 0, release enables byte 1
//
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   buttons_in       raw asynchronous pins
//   address_in       bus address, bits [3:2] decoded
//   sel_in           block select from the top-level decode
//   read_in          read strobe (reads have no side effects)
//   read_value_out   read data, zero when not selected (OR-bus)
//   write_mask_in    byte write enables
//   write_value_in   write data
//   ready_out        bus ready, equal to sel_in (zero wait states)
//   irq_out          registered level interrupt
// -----------------------------------------------------------------------------
module buttons_dev
    import buttons_pkg::*;
#(
    parameter int BUTTONCOUNT     = 4,
    parameter int DEBOUNCE_CYCLES = 36000,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [BUTTONCOUNT-1:0] buttons_in,
    input  logic [31:0]            address_in,
    input  logic                   sel_in,
    input  logic                   read_in,
    output logic [31:0]            read_value_out,
    input  logic [3:0]             write_mask_in,
    input  logic [31:0]            write_value_in,
    output logic                   ready_out,
    output logic                   irq_out
);

    localparam int BC = BUTTONCOUNT;

    logic [BC-1:0] stable_vec;
    logic [BC-1:0] rise_vec;
    logic [BC-1:0] fall_vec;

    logic [BC-1:0] press_r;
    logic [BC-1:0] release_r;
    logic [BC-1:0] irqen_press_r;
    logic [BC-1:0] irqen_release_r;
    logic          irq_r;

    reg_sel_e      reg_sel;
    logic          wr_b0;
    logic          wr_b1;
    logic [BC-1:0] press_clr;
    logic [BC-1:0] release_clr;
    logic [31:0]   rdata;

    // Only address bits [3:2], the low write bytes and nothing of read_in
    // matter here; fold the rest into a sink so the intent is explicit.
    logic          unused_bus;
    assign unused_bus = ^{address_in, write_value_in, write_mask_in, read_in};

    // Sticky event update: a set pulse always beats a same-cycle clear.
    function automatic logic [BC-1:0] event_next(input logic [BC-1:0] cur,
                                                 input logic [BC-1:0] set,
                                                 input logic [BC-1:0] clr);
        return (cur & ~clr) | set;
    endfunction

    for (genvar i = 0; i < BC; i++) begin : g_cell
        button_debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_cell (
            .clk       (clk),
            .reset     (reset),
            .raw_in    (buttons_in[i]),
            .stable_out(stable_vec[i]),
            .rise_out  (rise_vec[i]),
            .fall_out  (fall_vec[i])
        );
    end

    // Bus decode
    assign reg_sel = reg_sel_e'(address_in[3:2]);
    assign wr_b0   = sel_in & write_mask_in[0];
    assign wr_b1   = sel_in & write_mask_in[1];

    assign press_clr   = (wr_b0 && reg_sel == REG_PRESS)   ? write_value_in[BC-1:0] : '0;
    assign release_clr = (wr_b0 && reg_sel == REG_RELEASE) ? write_value_in[BC-1:0] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            press_r         <= '0;
            release_r       <= '0;
            irqen_press_r   <= '0;
            irqen_release_r <= '0;
            irq_r           <= 1'b0;
        end else begin
            press_r   <= event_next(press_r,   rise_vec, press_clr);
            release_r <= event_next(release_r, fall_vec, release_clr);
            if (wr_b0 && reg_sel == REG_IRQEN) begin
                irqen_press_r <= write_value_in[IRQEN_PRESS_LSB +: BC];
            end
            if (wr_b1 && reg_sel == REG_IRQEN) begin
                irqen_release_r <= write_value_in[IRQEN_RELEASE_LSB +: BC];
            end
            // Built from the registered event/enable state, so the interrupt
            // follows those registers by exactly one cycle.
            irq_r <= (|(press_r & irqen_press_r)) | (|(release_r & irqen_release_r));
        end
    end

    // Read mux
    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_STATE:   rdata[BC-1:0] = stable_vec;
            REG_PRESS:   rdata[BC-1:0] = press_r;
            REG_RELEASE: rdata[BC-1:0] = release_r;
            REG_IRQEN: begin
                rdata[IRQEN_PRESS_LSB +: BC]   = irqen_press_r;
                rdata[IRQEN_RELEASE_LSB +: BC] = irqen_release_r;
            end
            default: rdata = '0;
        endcase
    end

    assign read_value_out = sel_in ? rdata : 32'h0;
    assign ready_out      = sel_in;
    assign irq_out        = irq_r;

endmodule : buttons_dev
